// File: rtl/scontrol_cmd_tx.sv
// scontrol_cmd_tx: serialises 3-bit supply-control commands onto the strobed C[2:0]/CLK bus.
// Optional macro SCTX_FRAME_CNT_EN adds the 16-bit frame_cnt completed-frame counter port.
module scontrol_cmd_tx #(
    parameter int HALF_CYCLES = 64,
    parameter int GAP_CYCLES  = 128
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       cmd_valid,
    input  logic [2:0] cmd_code,
    output logic       cmd_ready,
    output logic       busy,
    output logic       cmd_done,
    output logic [2:0] bus_c,
    output logic       bus_clk
`ifdef SCTX_FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);
    typedef enum logic [2:0] {IDLE, SETUP, HIGH, HOLD, GAP} state_t;

    localparam logic [15:0] HALF_LOAD = 16'(HALF_CYCLES - 1);
    localparam logic [15:0] GAP_LOAD  = 16'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

    state_t      state, state_n;
    logic [15:0] timer, timer_n;
    logic [2:0]  idx, idx_n, idx_inc, code, code_n, bus_c_n;
    logic        done_n, last;

    // Discharge is [7,0,7,0,1]; every other opcode is [code,0].
    function automatic logic [2:0] word_of(input logic [2:0] c, input logic [2:0] i);
        return (c == 3'd7) ? ((i == 3'd4) ? 3'd1 : (i[0] ? 3'd0 : 3'd7))
                           : ((i == 3'd0) ? c : 3'd0);
    endfunction

    assign idx_inc = idx + 3'd1;
    assign last    = (code == 3'd7) ? (idx == 3'd4) : (idx == 3'd1);

    // Next-state: each strobe phase lasts HALF_CYCLES; bus_c only moves on HOLD exit.
    always_comb begin
        state_n = state;
        timer_n = timer;
        idx_n   = idx;
        code_n  = code;
        bus_c_n = bus_c;
        done_n  = 1'b0;
        case (state)
            IDLE: if (cmd_valid) begin
                state_n = SETUP;
                timer_n = HALF_LOAD;
                idx_n   = 3'd0;
                code_n  = cmd_code;
                bus_c_n = cmd_code;
            end
            SETUP: begin
                state_n = (timer == 16'd0) ? HIGH : SETUP;
                timer_n = (timer == 16'd0) ? HALF_LOAD : timer - 16'd1;
            end
            HIGH: begin
                state_n = (timer == 16'd0) ? HOLD : HIGH;
                timer_n = (timer == 16'd0) ? HALF_LOAD : timer - 16'd1;
            end
            HOLD: begin
                timer_n = timer - 16'd1;
                if (timer == 16'd0 && last) begin
                    bus_c_n = 3'd0;
                    done_n  = 1'b1;
                    state_n = (GAP_CYCLES == 0) ? IDLE : GAP;
                    timer_n = GAP_LOAD;
                end else if (timer == 16'd0) begin
                    idx_n   = idx_inc;
                    bus_c_n = word_of(code, idx_inc);
                    state_n = SETUP;
                    timer_n = HALF_LOAD;
                end
            end
            GAP: begin
                state_n = (timer == 16'd0) ? IDLE : GAP;
                timer_n = (timer == 16'd0) ? 16'd0 : timer - 16'd1;
            end
            default: state_n = IDLE;
        endcase
    end

    // State and registered outputs, all derived from the next state.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= IDLE;
            timer     <= 16'd0;
            idx       <= 3'd0;
            code      <= 3'd0;
            bus_c     <= 3'd0;
            bus_clk   <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            cmd_done  <= 1'b0;
        end else begin
            state     <= state_n;
            timer     <= timer_n;
            idx       <= idx_n;
            code      <= code_n;
            bus_c     <= bus_c_n;
            bus_clk   <= (state_n == HIGH);
            cmd_ready <= (state_n == IDLE);
            busy      <= (state_n != IDLE);
            cmd_done  <= done_n;
        end
    end

`ifdef SCTX_FRAME_CNT_EN
    // Completed-frame counter, bumps alongside cmd_done and wraps naturally.
    always_ff @(posedge clk) begin
        if (!rstn) frame_cnt <= 16'd0;
        else if (done_n) frame_cnt <= frame_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_scontrol_cmd_tx.sv
// tb_scontrol_cmd_tx: scoreboard bench for scontrol_cmd_tx with HALF_CYCLES=4 (GAP 2 and GAP 0 builds).
module tb_scontrol_cmd_tx;
    localparam int H = 4;
    localparam int G = 2;
    localparam int W = 3 * H;

    logic       clk = 0, rstn = 0, v = 0, v0 = 0;
    logic [2:0] code = 0, code0 = 0;
    logic       ready, busy, done, bus_clk, ready0, busy0, done0, bus_clk0;
    logic [2:0] bus_c, bus_c0;
`ifdef SCTX_FRAME_CNT_EN
    logic [15:0] fcnt, fcnt0;
`endif
    int errors = 0, checks = 0, frames = 0;
    logic [2:0] exp_q[$];
    logic       prev_clk = 0;
    logic [2:0] prev_c = 0, mon_e;

    scontrol_cmd_tx #(.HALF_CYCLES(H), .GAP_CYCLES(G)) dut (
        .clk(clk), .rstn(rstn), .cmd_valid(v), .cmd_code(code), .cmd_ready(ready),
        .busy(busy), .cmd_done(done), .bus_c(bus_c), .bus_clk(bus_clk)
`ifdef SCTX_FRAME_CNT_EN
        , .frame_cnt(fcnt)
`endif
    );

    scontrol_cmd_tx #(.HALF_CYCLES(H), .GAP_CYCLES(0)) dut0 (
        .clk(clk), .rstn(rstn), .cmd_valid(v0), .cmd_code(code0), .cmd_ready(ready0),
        .busy(busy0), .cmd_done(done0), .bus_c(bus_c0), .bus_clk(bus_clk0)
`ifdef SCTX_FRAME_CNT_EN
        , .frame_cnt(fcnt0)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] word_exp(input logic [2:0] c, input int w);
        logic [2:0] dis [5];
        dis = '{3'd7, 3'd0, 3'd7, 3'd0, 3'd1};
        return (c == 3'd7) ? dis[w] : ((w == 0) ? c : 3'd0);
    endfunction

    function automatic int nwords(input logic [2:0] c);
        return (c == 3'd7) ? 5 : 2;
    endfunction

    // Expected {bus_c, bus_clk, cmd_done, busy} in cycle t after an accept in cycle 0.
    function automatic logic [5:0] model(input logic [2:0] c, input int t, input int gap);
        int fl;
        logic [2:0] e_c;
        logic e_k;
        fl  = nwords(c) * W;
        e_c = 3'd0;
        e_k = 1'b0;
        if (t >= 1 && t <= fl) begin
            e_c = word_exp(c, (t - 1) / W);
            e_k = ((t - 1) % W) >= H && ((t - 1) % W) < 2 * H;
        end
        return {e_c, e_k, t == fl + 1, t >= 1 && t <= fl + gap};
    endfunction

    // Scoreboard: each falling strobe pops the next expected word; C must be stable while CLK is high.
    always @(negedge clk) begin
        if (rstn) begin
            if (prev_clk && bus_clk) begin
                checks++;
                if (bus_c !== prev_c) begin
                    errors++;
                    $display("FAIL stable_high: bus_c=%0d required %0d", bus_c, prev_c);
                end
            end
            if (prev_clk && !bus_clk) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL strobe_unexpected: bus_c=%0d required no strobe", bus_c);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (bus_c !== mon_e) begin
                        errors++;
                        $display("FAIL strobe_word: bus_c=%0d required %0d", bus_c, mon_e);
                    end
                end
            end
        end
        prev_clk = bus_clk;
        prev_c   = bus_c;
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rstn = 0;
        v = 0;
        v0 = 0;
        repeat (3) tick;
        checks++;
        if ({bus_c, bus_clk, ready, busy, done} !== 7'b000_0100) begin
            errors++;
            $display("FAIL reset_state: got %b required 0000100", {bus_c, bus_clk, ready, busy, done});
        end
        checks++;
        if ({bus_c0, bus_clk0, ready0, busy0, done0} !== 7'b000_0100) begin
            errors++;
            $display("FAIL reset_state_gap0: got %b required 0000100", {bus_c0, bus_clk0, ready0, busy0, done0});
        end
        rstn = 1;
        tick;
        checks++;
        if ({bus_c, bus_clk, ready, busy, done} !== 7'b000_0100) begin
            errors++;
            $display("FAIL after_release: got %b required 0000100", {bus_c, bus_clk, ready, busy, done});
        end
        exp_q.delete();
        frames = 0;
`ifdef SCTX_FRAME_CNT_EN
        checks++;
        if (fcnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_frame_cnt: got %0d required 0", fcnt);
        end
`endif
    endtask

    task automatic test_frame(input logic [2:0] c);
        logic [5:0] e;
        int fl;
        fl = nwords(c) * W;
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_ready code=%0d: got %b required 1", c, ready);
        end
        v = 1;
        code = c;
        for (int w = 0; w < nwords(c); w++) exp_q.push_back(word_exp(c, w));
        for (int t = 1; t <= fl + G + 1; t++) begin
            tick;
            v = 0;
            e = model(c, t, G);
            if (e[1]) frames++;
            checks++;
            if ({bus_c, bus_clk, done, busy, ready} !== {e, ~e[0]}) begin
                errors++;
                $display("FAIL frame_code%0d t=%0d: {c,clk,done,busy,ready}=%b required %b",
                         c, t, {bus_c, bus_clk, done, busy, ready}, {e, ~e[0]});
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL strobe_count code=%0d: %0d words unsent required 0", c, exp_q.size());
            exp_q.delete();
        end
`ifdef SCTX_FRAME_CNT_EN
        checks++;
        if (fcnt !== 16'(frames)) begin
            errors++;
            $display("FAIL frame_cnt code=%0d: got %0d required %0d", c, fcnt, frames);
        end
`endif
    endtask

    task automatic test_back_to_back;
        logic [5:0] e;
        v = 1;
        code = 3'd5;
        exp_q.push_back(3'd5);
        exp_q.push_back(3'd0);
        for (int t = 1; t <= 54; t++) begin
            tick;
            if (t == 1) begin
                code = 3'd6;
                exp_q.push_back(3'd6);
                exp_q.push_back(3'd0);
            end
            if (t == 28) v = 0;
            e = model(3'd5, t, G) | model(3'd6, t - 27, G);
            checks++;
            if ({bus_c, bus_clk, done, busy, ready} !== {e, ~e[0]}) begin
                errors++;
                $display("FAIL back_to_back t=%0d: {c,clk,done,busy,ready}=%b required %b",
                         t, {bus_c, bus_clk, done, busy, ready}, {e, ~e[0]});
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL back_to_back_strobes: %0d words unsent required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_ignore_busy;
        logic [5:0] e;
        int threes;
        threes = 0;
        v = 1;
        code = 3'd1;
        exp_q.push_back(3'd1);
        exp_q.push_back(3'd0);
        for (int t = 1; t <= 28; t++) begin
            tick;
            v = (t >= 2 && t <= 20);
            code = (t >= 2 && t <= 20) ? 3'd3 : 3'd1;
            if (bus_c == 3'd3) threes++;
            e = model(3'd1, t, G);
            checks++;
            if ({bus_c, bus_clk, done, busy, ready} !== {e, ~e[0]}) begin
                errors++;
                $display("FAIL ignore_busy t=%0d: {c,clk,done,busy,ready}=%b required %b",
                         t, {bus_c, bus_clk, done, busy, ready}, {e, ~e[0]});
            end
        end
        checks++;
        if (threes != 0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL ignore_busy_summary: bus_c==3 cycles=%0d pending=%0d required 0 and 0", threes, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset_mid;
        logic [5:0] e;
        v = 1;
        code = 3'd2;
        exp_q.push_back(3'd2);
        exp_q.push_back(3'd0);
        for (int t = 1; t <= 20; t++) begin
            tick;
            v = 0;
            if (t == 16) rstn = 1;
            e = (t <= 15) ? model(3'd2, t, G) : 6'd0;
            checks++;
            if ({bus_c, bus_clk, done, busy, ready} !== {e, ~e[0]}) begin
                errors++;
                $display("FAIL reset_mid t=%0d: {c,clk,done,busy,ready}=%b required %b",
                         t, {bus_c, bus_clk, done, busy, ready}, {e, ~e[0]});
            end
            if (t == 15) begin
                rstn = 0;
                exp_q.delete();
                frames = 0;
            end
        end
`ifdef SCTX_FRAME_CNT_EN
        checks++;
        if (fcnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_mid_frame_cnt: got %0d required 0", fcnt);
        end
`endif
        test_frame(3'd2);
    endtask

    task automatic test_gap0;
        logic [5:0] e;
        v0 = 1;
        code0 = 3'd0;
        for (int t = 1; t <= 26; t++) begin
            tick;
            v0 = 0;
            e = model(3'd0, t, 0);
            checks++;
            if ({bus_c0, bus_clk0, done0, busy0, ready0} !== {e, ~e[0]}) begin
                errors++;
                $display("FAIL gap0 t=%0d: {c,clk,done,busy,ready}=%b required %b",
                         t, {bus_c0, bus_clk0, done0, busy0, ready0}, {e, ~e[0]});
            end
        end
`ifdef SCTX_FRAME_CNT_EN
        checks++;
        if (fcnt0 !== 16'd1) begin
            errors++;
            $display("FAIL gap0_frame_cnt: got %0d required 1", fcnt0);
        end
`endif
    endtask

    initial begin
        test_reset;
        test_frame(3'd1);
        test_frame(3'd7);
        test_frame(3'd4);
        test_back_to_back;
        test_ignore_busy;
        test_reset_mid;
        test_gap0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/scontrol_cmd_tx.md
Name: scontrol_cmd_tx

Overview:
- Command transmitter for the supply-control strobed bus: 3-bit data C[2:0] plus a strobe line CLK. The receiver samples C on the falling edge of CLK.
- Sits on the host/controller side. Takes one 3-bit command per valid/ready handshake and serialises it into the protocol word frame.
- Drives slow, filter-safe edges so the receiver's 16-tap input glitch filters see stable levels.

Parameters:
- HALF_CYCLES, 64, length in clk cycles of each strobe phase (setup, high, hold). Legal range 17..65535 (must exceed the receiver filter depth of 16).
- GAP_CYCLES, 128, idle clk cycles inserted after each frame before the next accept. Legal range 0..65535; 0 skips the gap.

Ports:
- clk  in  1  system clock
- rstn  in  1  synchronous active-low reset
- cmd_valid  in  1  command request
- cmd_code  in  3  opcode: 0 pause, 1 plus, 2 minus, 3 ballast+, 4 ballast-, 5 start, 6 shutdown, 7 discharge
- cmd_ready  out  1  high only in IDLE; accept occurs when cmd_valid && cmd_ready
- busy  out  1  high whenever state != IDLE
- cmd_done  out  1  one-cycle pulse at end of last word of a frame
- bus_c  out  3  C[2:0] data lines
- bus_clk  out  1  CLK strobe line
- frame_cnt  out  16  frames completed; present only with SCTX_FRAME_CNT_EN

Behaviour:
- Reset: synchronous, applied when rstn=0 at a clk edge. Reset values: state IDLE, bus_c=0, bus_clk=0, cmd_ready=1, busy=0, cmd_done=0, timer=0, word index=0, frame_cnt=0.
- Frame content, latched at accept:
  - codes 0..6 send the 2-word frame [code, 0]
  - code 7 sends the 5-word frame [7, 0, 7, 0, 1]
- Word index: 3 bits. Timer: 16 bits, loaded with HALF_CYCLES-1 or GAP_CYCLES-1 and decremented to 0.
- FSM states: IDLE, SETUP, HIGH, HOLD, GAP.
- IDLE:
  - bus_c=0, bus_clk=0, cmd_ready=1.
  - On accept at edge k: latch code, word index=0, enter SETUP.
  - From cycle k+1: bus_c=word0.
- SETUP: bus_clk=0, bus_c=current word, held HALF_CYCLES cycles, then go to HIGH.
- HIGH: bus_clk=1, bus_c unchanged, held HALF_CYCLES cycles, then go to HOLD. The HIGH->HOLD edge is the falling edge the receiver samples on.
- HOLD: bus_clk=0, bus_c unchanged, held HALF_CYCLES cycles, then:
  - more words remain: increment index, bus_c=next word, go to SETUP. bus_c changes only on this transition.
  - last word:
    - bus_c=0
    - cmd_done=1 for exactly that next cycle
    - frame_cnt increments in that same cycle
    - go to GAP, or to IDLE if GAP_CYCLES=0
- GAP: bus idle (bus_c=0, bus_clk=0) for GAP_CYCLES cycles, then go to IDLE.
- Timing per frame:
  - each word lasts 3*HALF_CYCLES cycles
  - 2-word frame: 6*HALF_CYCLES cycles
  - discharge frame: 15*HALF_CYCLES cycles
- cmd_valid and cmd_code are ignored while busy; no queuing.
- bus_c never changes while bus_clk=1, and never changes within HALF_CYCLES cycles of a falling edge.
- Reset mid-frame: outputs go idle on the next edge and the frame is lost, with no cmd_done. The receiver may be left mid-frame. Software recovers by sending opcode 0 (pause), which completes any pending 2-word state harmlessly.
- frame_cnt wraps from 0xFFFF to 0.
- All outputs are registered.

Optional Feature:
- Macro SCTX_FRAME_CNT_EN.
- When defined: port frame_cnt exists and is a 16-bit counter of completed frames, reset to 0 and wrapping.
- When undefined: the frame_cnt port and counter logic are absent. All other behaviour is identical.

Test Plan (all with HALF_CYCLES=4, GAP_CYCLES=2, accept at cycle 0):
- cmd_code=1 accept -> expected response:
  - bus_c=1 in cycles 1-12, bus_clk=1 in cycles 5-8
  - bus_c=0 in cycles 13-24, bus_clk=1 in cycles 17-20
  - cmd_done pulse at cycle 25
  - cmd_ready high again at cycle 27
- cmd_code=7 accept -> bus_c sequence 7,0,7,0,1, each word 12 cycles long with 5 falling edges; cmd_done at cycle 61; frame_cnt=1.
- cmd_valid held high with codes 5 then 6 -> second accept at cycle 27; second frame is [6,0]; busy low only in cycle 27 before re-accept.
- cmd_valid pulsed with code 3 during cycles 2-20 of an active frame -> ignored; only the original frame is transmitted and bus_c is never 3.
- rstn=0 at cycle 15 of a code-2 frame -> from cycle 16: bus_c=0, bus_clk=0, cmd_ready=1, no cmd_done; a new accept after release sends a full frame.
- GAP_CYCLES=0 build, code 0 -> cmd_done at cycle 25 and cmd_ready=1 at cycle 25 (same cycle).
